// File: rtl/demux_stream_1xn_if.sv
// Stream bus of the 1-to-N demux: one valid/ready input stream in,
// N_OUT registered valid/ready channels out.
interface demux_stream_1xn_if #(
  parameter int WIDTH = 4,
  parameter int N_OUT = 8
);
  localparam int SEL_W = $clog2(N_OUT);

  logic [WIDTH-1:0]            data_i;
  logic [SEL_W-1:0]            sel_i;
  logic                        bcast_i;
  logic                        valid_i;
  logic                        ready_o;
  logic [N_OUT-1:0][WIDTH-1:0] data_o;
  logic [N_OUT-1:0]            valid_o;
  logic [N_OUT-1:0]            ready_i;

  // Demux side.
  modport slave (
    input  data_i, sel_i, bcast_i, valid_i, ready_i,
    output ready_o, data_o, valid_o
  );

  // Environment side: producer plus the N consumers.
  modport master (
    output data_i, sel_i, bcast_i, valid_i, ready_i,
    input  ready_o, data_o, valid_o
  );
endinterface

// File: rtl/demux_stream_1xn.sv
// Registered 1-to-N stream demux with broadcast, per-channel one-entry
// output slots, and a sticky error / saturating drop counter for beats
// whose select is out of range.

// One output channel slot: load wins over drain, payload zeroed when empty.
module demux_stream_1xn_slot #(
  parameter int WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);
  // Slot register: load, drain to zero, or hold under stall.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_o <= 1'b0;
      data_o  <= '0;
    end else if (load_i) begin
      valid_o <= 1'b1;
      data_o  <= data_i;
    end else if (valid_o && ready_i) begin
      valid_o <= 1'b0;
      data_o  <= '0;
    end
  end
endmodule

module demux_stream_1xn #(
  parameter int WIDTH = 4,
  parameter int N_OUT = 8,
  parameter int SEL_W = $clog2(N_OUT),
  parameter int CNT_W = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  demux_stream_1xn_if.slave    bus,
  input  logic                 err_clr_i,
  output logic                 err_o,
  output logic [CNT_W-1:0]     drop_cnt_o
);
  // Extra bit so N_OUT itself is representable when N_OUT is a power of 2.
  localparam logic [SEL_W:0] N_OUT_L = (SEL_W+1)'(N_OUT);

  logic [N_OUT-1:0]            slot_vld;
  logic [N_OUT-1:0][WIDTH-1:0] slot_dat;
  logic [N_OUT-1:0]            free;
  logic [N_OUT-1:0]            load;
  logic                        in_range;
  logic                        ready;
  logic                        accept;
  logic                        drop;

  assign free     = ~slot_vld | bus.ready_i;
  assign in_range = {1'b0, bus.sel_i} < N_OUT_L;
  assign accept   = bus.valid_i && ready;
  assign drop     = accept && !bus.bcast_i && !in_range;

  assign bus.ready_o = ready;
  assign bus.valid_o = slot_vld;
  assign bus.data_o  = slot_dat;

  // Input ready: broadcast needs every slot free, unicast only its target;
  // out-of-range unicast is always swallowed. Never ready in reset.
  always_comb begin
    ready = 1'b0;
    if (!rst_ni)          ready = 1'b0;
    else if (bus.bcast_i) ready = &free;
    else if (in_range)    ready = free[bus.sel_i];
    else                  ready = 1'b1;
  end

  // Slot load strobes for the accepted beat.
  always_comb begin
    load = '0;
    for (int k = 0; k < N_OUT; k++)
      load[k] = accept && (bus.bcast_i || (in_range && bus.sel_i == SEL_W'(k)));
  end

  for (genvar g = 0; g < N_OUT; g++) begin : g_slot
    demux_stream_1xn_slot #(.WIDTH(WIDTH)) u_slot (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .load_i  (load[g]),
      .data_i  (bus.data_i),
      .ready_i (bus.ready_i[g]),
      .valid_o (slot_vld[g]),
      .data_o  (slot_dat[g])
    );
  end

  // Drop bookkeeping: clear beats a same-cycle drop; counter saturates.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_o      <= 1'b0;
      drop_cnt_o <= '0;
    end else if (err_clr_i) begin
      err_o      <= 1'b0;
      drop_cnt_o <= '0;
    end else if (drop) begin
      err_o <= 1'b1;
      if (drop_cnt_o != '1) drop_cnt_o <= drop_cnt_o + 1'b1;
    end
  end

`ifndef SYNTHESIS
  for (genvar g = 0; g < N_OUT; g++) begin : g_chk
    a_hold: assert property (@(posedge clk_i) disable iff (!rst_ni)
      slot_vld[g] && !bus.ready_i[g] |=> slot_vld[g] && $stable(slot_dat[g]));
    a_zero: assert property (@(posedge clk_i) disable iff (!rst_ni)
      !slot_vld[g] |-> slot_dat[g] == '0);
  end
  a_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni)
    accept && !bus.bcast_i |-> $onehot0(load));
`endif
endmodule

// File: tb/tb_demux_stream_1xn.sv
// Bench for demux_stream_1xn: instance 0 is 8 channels / 8-bit counter,
// instance 1 is 5 channels / 2-bit counter (out-of-range and saturation).
module tb_demux_stream_1xn;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  logic chk_on = 1'b0;

  // Stimulus, one set per instance.
  logic [3:0] d_data [2];
  logic [2:0] d_sel [2];
  logic       d_bcast [2];
  logic       d_valid [2];
  logic       d_clr [2];
  logic [7:0] d_rdy [2];

  // Outputs widened to the 8-channel shape.
  logic        o_ready [2];
  logic [7:0]  o_valid [2];
  logic [31:0] o_data [2];
  logic        o_err [2];
  logic [7:0]  o_cnt [2];
  logic [1:0]  cnt_b;

  demux_stream_1xn_if #(.WIDTH(4), .N_OUT(8)) ia ();
  demux_stream_1xn_if #(.WIDTH(4), .N_OUT(5)) ib ();

  assign ia.data_i  = d_data[0];
  assign ia.sel_i   = d_sel[0];
  assign ia.bcast_i = d_bcast[0];
  assign ia.valid_i = d_valid[0];
  assign ia.ready_i = d_rdy[0];
  assign ib.data_i  = d_data[1];
  assign ib.sel_i   = d_sel[1];
  assign ib.bcast_i = d_bcast[1];
  assign ib.valid_i = d_valid[1];
  assign ib.ready_i = d_rdy[1][4:0];

  assign o_ready[0] = ia.ready_o;
  assign o_valid[0] = ia.valid_o;
  assign o_data[0]  = ia.data_o;
  assign o_ready[1] = ib.ready_o;
  assign o_valid[1] = {3'b0, ib.valid_o};
  assign o_data[1]  = {12'b0, ib.data_o};
  assign o_cnt[1]   = {6'b0, cnt_b};

  demux_stream_1xn #(.WIDTH(4), .N_OUT(8), .CNT_W(8)) u_a (
    .clk_i(clk), .rst_ni(rst_n), .bus(ia),
    .err_clr_i(d_clr[0]), .err_o(o_err[0]), .drop_cnt_o(o_cnt[0]));

  demux_stream_1xn #(.WIDTH(4), .N_OUT(5), .CNT_W(2)) u_b (
    .clk_i(clk), .rst_ni(rst_n), .bus(ib),
    .err_clr_i(d_clr[1]), .err_o(o_err[1]), .drop_cnt_o(cnt_b));

  // ---------------- behavioural model ----------------
  logic       mv [2][8];
  logic [3:0] md [2][8];
  logic       merr [2];
  int         mcnt [2];

  function automatic int nout(int i);
    return (i == 0) ? 8 : 5;
  endfunction

  function automatic int cmax(int i);
    return (i == 0) ? 255 : 3;
  endfunction

  function automatic logic exp_ready(int i);
    int s;
    s = int'(d_sel[i]);
    if (!rst_n) return 1'b0;
    if (d_bcast[i]) begin
      for (int k = 0; k < nout(i); k++)
        if (mv[i][k] && !d_rdy[i][k]) return 1'b0;
      return 1'b1;
    end
    if (s >= nout(i)) return 1'b1;
    return !mv[i][s] || d_rdy[i][s];
  endfunction

  // Model state advance on each edge, from the beat rules.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        for (int k = 0; k < 8; k++) begin
          mv[i][k] <= 1'b0;
          md[i][k] <= 4'h0;
        end
        merr[i] <= 1'b0;
        mcnt[i] <= 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        logic acc, drp;
        acc = d_valid[i] && exp_ready(i);
        drp = acc && !d_bcast[i] && (int'(d_sel[i]) >= nout(i));
        for (int k = 0; k < nout(i); k++) begin
          if (acc && (d_bcast[i] || int'(d_sel[i]) == k)) begin
            mv[i][k] <= 1'b1;
            md[i][k] <= d_data[i];
          end else if (mv[i][k] && d_rdy[i][k]) begin
            mv[i][k] <= 1'b0;
            md[i][k] <= 4'h0;
          end
        end
        if (d_clr[i]) begin
          merr[i] <= 1'b0;
          mcnt[i] <= 0;
        end else if (drp) begin
          merr[i] <= 1'b1;
          if (mcnt[i] < cmax(i)) mcnt[i] <= mcnt[i] + 1;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      for (int i = 0; i < 2; i++) begin
        logic [7:0]  ev;
        logic [31:0] ed;
        ev = '0;
        ed = '0;
        for (int k = 0; k < nout(i); k++) begin
          ev[k] = mv[i][k];
          ed[4*k +: 4] = md[i][k];
        end
        chk($sformatf("m%0d ready", i), 32'(o_ready[i]), 32'(exp_ready(i)));
        chk($sformatf("m%0d valid", i), 32'(o_valid[i]), 32'(ev));
        chk($sformatf("m%0d data", i), o_data[i], ed);
        chk($sformatf("m%0d err", i), 32'(o_err[i]), 32'(merr[i]));
        chk($sformatf("m%0d cnt", i), 32'(o_cnt[i]), 32'(mcnt[i]));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed stimulus with literal expectations ----------------
  initial begin
    for (int i = 0; i < 2; i++) begin
      d_data[i] = '0; d_sel[i] = '0; d_bcast[i] = 1'b0;
      d_valid[i] = 1'b0; d_clr[i] = 1'b0; d_rdy[i] = 8'hFF;
    end
    step();
    chk_on = 1'b1;
    chk("rst valid", 32'(o_valid[0]), 32'h0);
    chk("rst ready", 32'(o_ready[0]), 32'h0);
    chk("rst cnt", 32'(o_cnt[1]), 32'h0);
    step();
    rst_n = 1'b1;

    // Unicast sweep: one-hot valid, payload sel+1 in its lane only.
    for (int s = 0; s < 8; s++) begin
      d_valid[0] = 1'b1; d_sel[0] = 3'(s); d_data[0] = 4'(s + 1);
      #1 chk("sweep ready", 32'(o_ready[0]), 32'h1);
      step();
      chk("sweep valid", 32'(o_valid[0]), 32'h1 << s);
      chk("sweep data", o_data[0], 32'(s + 1) << (4 * s));
    end
    d_valid[0] = 1'b0;
    step();
    chk("sweep idle", 32'(o_valid[0]), 32'h0);

    // Back-pressure on channel 3, channel 5 unaffected.
    d_rdy[0] = 8'hF7;
    d_valid[0] = 1'b1; d_sel[0] = 3'd3; d_data[0] = 4'hA;
    step();
    chk("bp first", o_data[0], 32'h0000A000);
    d_data[0] = 4'hB;
    #1 chk("bp stall ready", 32'(o_ready[0]), 32'h0);
    step();
    chk("bp hold", o_data[0], 32'h0000A000);
    chk("bp hold valid", 32'(o_valid[0]), 32'h08);
    d_sel[0] = 3'd5; d_data[0] = 4'h5;
    #1 chk("bp side ready", 32'(o_ready[0]), 32'h1);
    step();
    chk("bp side data", o_data[0], 32'h0050A000);
    d_sel[0] = 3'd3; d_data[0] = 4'hB; d_rdy[0] = 8'hFF;
    #1 chk("bp release ready", 32'(o_ready[0]), 32'h1);
    step();
    chk("bp swap data", o_data[0], 32'h0000B000);
    chk("bp swap valid", 32'(o_valid[0]), 32'h08);
    d_valid[0] = 1'b0;
    step();

    // Broadcast blocked by full stalled slot 6, then delivered to all.
    d_rdy[0] = 8'hBF;
    d_valid[0] = 1'b1; d_sel[0] = 3'd6; d_data[0] = 4'h9;
    step();
    d_bcast[0] = 1'b1; d_data[0] = 4'hC;
    #1 chk("bc blocked ready", 32'(o_ready[0]), 32'h0);
    step();
    chk("bc blocked data", o_data[0], 32'h09000000);
    d_rdy[0] = 8'hFF;
    #1 chk("bc ready", 32'(o_ready[0]), 32'h1);
    step();
    chk("bc valid", 32'(o_valid[0]), 32'hFF);
    chk("bc data", o_data[0], 32'hCCCCCCCC);
    d_valid[0] = 1'b0; d_bcast[0] = 1'b0;
    step();

    // Out-of-range drops on the 5-channel instance.
    d_valid[1] = 1'b1; d_sel[1] = 3'd6; d_data[1] = 4'hF;
    repeat (3) begin
      #1 chk("oor ready", 32'(o_ready[1]), 32'h1);
      step();
    end
    chk("oor valid", 32'(o_valid[1]), 32'h0);
    chk("oor err", 32'(o_err[1]), 32'h1);
    chk("oor cnt", 32'(o_cnt[1]), 32'h3);
    d_clr[1] = 1'b1;
    step();
    chk("clr err", 32'(o_err[1]), 32'h0);
    chk("clr cnt", 32'(o_cnt[1]), 32'h0);
    d_clr[1] = 1'b0;
    repeat (5) step();
    chk("sat cnt", 32'(o_cnt[1]), 32'h3);
    // Highest in-range channel, then broadcast with an out-of-range select.
    d_sel[1] = 3'd4; d_data[1] = 4'h4;
    step();
    chk("last ch", o_data[1], 32'h00040000);
    d_bcast[1] = 1'b1; d_sel[1] = 3'd6; d_data[1] = 4'hD;
    step();
    chk("bc oor valid", 32'(o_valid[1]), 32'h1F);
    chk("bc oor data", o_data[1], 32'h000DDDDD);
    chk("bc oor cnt", 32'(o_cnt[1]), 32'h3);
    d_valid[1] = 1'b0; d_bcast[1] = 1'b0;
    step();

    // Asynchronous reset with slots 1 and 2 held.
    d_rdy[0] = 8'hF9;
    d_valid[0] = 1'b1; d_sel[0] = 3'd1; d_data[0] = 4'h1;
    step();
    d_sel[0] = 3'd2; d_data[0] = 4'h2;
    step();
    d_sel[0] = 3'd0; d_data[0] = 4'h7;
    chk("pre rst data", o_data[0], 32'h00000210);
    #2 rst_n = 1'b0;
    #1;
    chk("arst valid", 32'(o_valid[0]), 32'h0);
    chk("arst data", o_data[0], 32'h0);
    chk("arst ready", 32'(o_ready[0]), 32'h0);
    step();
    step();
    rst_n = 1'b1;
    d_rdy[0] = 8'hFF;
    #1 chk("resume ready", 32'(o_ready[0]), 32'h1);
    step();
    chk("resume data", o_data[0], 32'h00000007);
    chk("resume valid", 32'(o_valid[0]), 32'h01);
    d_valid[0] = 1'b0;
    step();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
